// File: rtl/pad_bidir_ctrl.sv
// pad_bidir_ctrl: sequenced bidirectional GPIO pad controller.
// Turns a single pad between receive and drive with hi-Z dead cycles in between.
// The received level goes through a 2-flop synchronizer, a persistence filter and an edge detector.
// Optional build macro PAD_BIDIR_CTRL_READBACK_EN adds a sticky drive/readback contention flag (err).
module pad_bidir_ctrl #(
  parameter int unsigned TURN_CYCLES = 2,    // 1..15
  parameter int unsigned FILT_CYCLES = 3,    // 0..255, 0 = no filtering
  parameter bit          RESET_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic dir_req,
  input  logic dout,
  inout  wire  pad,
  output logic din,
  output logic din_rise,
  output logic din_fall,
  output logic oe,
  output logic busy,
  output logic err,
  input  logic err_clr
);

  typedef enum logic [1:0] {S_IN, S_TURN_OUT, S_OUT, S_TURN_IN} state_t;

  localparam logic [3:0] TLOAD = 4'(TURN_CYCLES - 1);
  localparam logic [7:0] FLIM  = 8'(FILT_CYCLES);

  state_t     state, state_nxt;
  logic [3:0] tcnt, tcnt_nxt;
  logic       dout_q;
  logic       s1, s2;
  logic [7:0] fcnt;

  // State and turnaround counter; async reset drops oe without waiting for a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IN;
      tcnt  <= '0;
    end else begin
      state <= state_nxt;
      tcnt  <= tcnt_nxt;
    end
  end

  // Next state: tcnt holds the remaining dead cycles after the current one.
  always_comb begin
    state_nxt = state;
    tcnt_nxt  = tcnt;
    oe        = 1'b0;
    busy      = 1'b0;
    case (state)
      S_IN: begin
        if (dir_req) begin
          state_nxt = S_TURN_OUT;
          tcnt_nxt  = TLOAD;
        end
      end
      S_TURN_OUT: begin
        busy = 1'b1;
        // A dropped request aborts at once; oe never asserts.
        if (!dir_req)          state_nxt = S_IN;
        else if (tcnt == 4'd0) state_nxt = S_OUT;
        else                   tcnt_nxt  = tcnt - 4'd1;
      end
      S_OUT: begin
        oe = 1'b1;
        if (!dir_req) begin
          state_nxt = S_TURN_IN;
          tcnt_nxt  = TLOAD;
        end
      end
      S_TURN_IN: begin
        busy = 1'b1;
        // Always completes the full dead time, whatever dir_req does.
        if (tcnt == 4'd0) state_nxt = S_IN;
        else              tcnt_nxt  = tcnt - 4'd1;
      end
      default: state_nxt = S_IN;
    endcase
  end

  // Output data register: one cycle dout-to-pad latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) dout_q <= 1'b0;
    else     dout_q <= dout;
  end

  assign pad = oe ? dout_q : 1'bz;

  // Synchronizer runs in drive mode too so the driven level reads back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= RESET_LEVEL;
      s2 <= RESET_LEVEL;
    end else begin
      s1 <= pad;
      s2 <= s1;
    end
  end

  // Persistence filter plus edge pulses; fcnt never exceeds FLIM so it cannot wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      din      <= RESET_LEVEL;
      fcnt     <= '0;
      din_rise <= 1'b0;
      din_fall <= 1'b0;
    end else begin
      din_rise <= 1'b0;
      din_fall <= 1'b0;
      if (s2 == din) begin
        fcnt <= '0;
      end else if (fcnt >= FLIM) begin
        din      <= s2;
        fcnt     <= '0;
        din_rise <= s2;
        din_fall <= ~s2;
      end else begin
        fcnt <= fcnt + 8'd1;
      end
    end
  end

`ifdef PAD_BIDIR_CTRL_READBACK_EN
  logic       dq1, dq2;
  logic [1:0] ocnt;
  logic       cmp_en;

  // Compare only once the first driven value has had time to reach s2.
  assign cmp_en = (state == S_OUT) && (ocnt == 2'd2);

  // Delay dout_q to line up with s2 and count consecutive cycles in OUT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dq1  <= 1'b0;
      dq2  <= 1'b0;
      ocnt <= '0;
    end else begin
      dq1 <= dout_q;
      dq2 <= dq1;
      if (state != S_OUT)    ocnt <= '0;
      else if (ocnt != 2'd2) ocnt <= ocnt + 2'd1;
    end
  end

  // Sticky contention flag; a new mismatch beats a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      err <= 1'b0;
    else if (cmp_en && s2 != dq2) err <= 1'b1;
    else if (err_clr)             err <= 1'b0;
  end
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_pad_bidir_ctrl.sv
// Bench for pad_bidir_ctrl at default parameters (TURN_CYCLES=2, FILT_CYCLES=3, RESET_LEVEL=0).
// Expected outputs are queued when inputs are driven and checked after the following edge.
module tb_pad_bidir_ctrl;
  logic clk = 1'b0, rst = 1'b1, dir_req = 1'b0, dout = 1'b0, err_clr = 1'b0;
  logic tb_en = 1'b1, tb_val = 1'b1;
  logic din, din_rise, din_fall, oe, busy, err;
  wire  pad;

  assign pad = tb_en ? tb_val : 1'bz;
  always #5 clk = ~clk;

  pad_bidir_ctrl dut (
    .clk(clk), .rst(rst), .dir_req(dir_req), .dout(dout), .pad(pad),
    .din(din), .din_rise(din_rise), .din_fall(din_fall), .oe(oe),
    .busy(busy), .err(err), .err_clr(err_clr)
  );

  typedef struct {
    logic md;   // din/rise/fall are meaningful
    logic din, rise, fall, oe, busy, pad;
  } exp_t;

  exp_t  exp_q[$];
  int    checks = 0, errors = 0;
  string phase = "init";

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s.%s got %0h exp %0h", phase, tag, obs, expv);
    end
  endtask

  function automatic exp_t ex(input logic md, input logic d, input logic r, input logic f,
                              input logic o, input logic b);
    exp_t t;
    t.md = md; t.din = d; t.rise = r; t.fall = f; t.oe = o; t.busy = b; t.pad = 1'b0;
    return t;
  endfunction

  task automatic check_front();
    exp_t t;
    t = exp_q.pop_front();
    chk("oe", oe, t.oe);
    chk("busy", busy, t.busy);
    chk("err", err, 1'b0);
    if (t.md) begin
      chk("din", din, t.din);
      chk("rise", din_rise, t.rise);
      chk("fall", din_fall, t.fall);
    end
    if (t.oe) chk("pad", pad, t.pad);
  endtask

  // Entered at posedge+1: drive inputs for the next edge, then check the edge just passed
  // (dout already changed, so pad must still show the registered value).
  task automatic cyc(input logic dr, input logic dv, input logic pen, input logic pv, input exp_t e);
    exp_t t;
    dir_req = dr; dout = dv; tb_en = pen; tb_val = pv;
    #1;
    if (exp_q.size() != 0) check_front();
    t = e; t.pad = dv;
    exp_q.push_back(t);
    @(posedge clk); #1;
  endtask

  task automatic flush();
    #1;
    while (exp_q.size() != 0) check_front();
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset with pad held high by the bench.
    phase = "reset";
    repeat (3) @(posedge clk);
    #1;
    chk("din", din, 1'b0);
    chk("oe", oe, 1'b0);
    chk("busy", busy, 1'b0);
    chk("rise", din_rise, 1'b0);
    chk("fall", din_fall, 1'b0);
    chk("err", err, 1'b0);
    rst = 1'b0;

    // Pad high since reset: din rises on the 6th edge with a single pulse.
    phase = "rst_rel";
    for (int i = 1; i <= 8; i++) cyc(1'b0, 1'b0, 1'b1, 1'b1, ex(1'b1, i >= 6, i == 6, 1'b0, 1'b0, 1'b0));
    flush();

    // Full turnaround into drive, data toggles, back to receive.
    phase = "drive";
    cyc(1'b1, 1'b0, 1'b0, 1'b0, ex(1'b0, 0, 0, 0, 1'b0, 1'b1));
    cyc(1'b1, 1'b0, 1'b0, 1'b0, ex(1'b0, 0, 0, 0, 1'b0, 1'b1));
    cyc(1'b1, 1'b1, 1'b0, 1'b0, ex(1'b0, 0, 0, 0, 1'b1, 1'b0));
    cyc(1'b1, 1'b0, 1'b0, 1'b0, ex(1'b0, 0, 0, 0, 1'b1, 1'b0));
    cyc(1'b1, 1'b1, 1'b0, 1'b0, ex(1'b0, 0, 0, 0, 1'b1, 1'b0));
    cyc(1'b0, 1'b1, 1'b0, 1'b0, ex(1'b0, 0, 0, 0, 1'b0, 1'b1));
    cyc(1'b0, 1'b0, 1'b0, 1'b0, ex(1'b0, 0, 0, 0, 1'b0, 1'b1));
    cyc(1'b0, 1'b0, 1'b0, 1'b0, ex(1'b0, 0, 0, 0, 1'b0, 1'b0));
    cyc(1'b0, 1'b0, 1'b0, 1'b0, ex(1'b0, 0, 0, 0, 1'b0, 1'b0));
    flush();

    // TURN_IN ignores a returning request, then IN re-enters TURN_OUT; a drop aborts it.
    phase = "reenter";
    cyc(1'b1, 1'b0, 1'b0, 1'b0, ex(1'b0, 0, 0, 0, 1'b0, 1'b1));
    cyc(1'b1, 1'b0, 1'b0, 1'b0, ex(1'b0, 0, 0, 0, 1'b0, 1'b1));
    cyc(1'b1, 1'b0, 1'b0, 1'b0, ex(1'b0, 0, 0, 0, 1'b1, 1'b0));
    cyc(1'b0, 1'b0, 1'b0, 1'b0, ex(1'b0, 0, 0, 0, 1'b0, 1'b1));
    cyc(1'b1, 1'b0, 1'b0, 1'b0, ex(1'b0, 0, 0, 0, 1'b0, 1'b1));
    cyc(1'b1, 1'b0, 1'b0, 1'b0, ex(1'b0, 0, 0, 0, 1'b0, 1'b0));
    cyc(1'b1, 1'b0, 1'b0, 1'b0, ex(1'b0, 0, 0, 0, 1'b0, 1'b1));
    cyc(1'b0, 1'b0, 1'b0, 1'b0, ex(1'b0, 0, 0, 0, 1'b0, 1'b0));
    flush();

    // One-cycle request: TURN_OUT aborts, oe never rises.
    phase = "pulse";
    cyc(1'b1, 1'b1, 1'b0, 1'b0, ex(1'b0, 0, 0, 0, 1'b0, 1'b1));
    cyc(1'b0, 1'b1, 1'b0, 1'b0, ex(1'b0, 0, 0, 0, 1'b0, 1'b0));
    cyc(1'b0, 1'b1, 1'b0, 1'b0, ex(1'b0, 0, 0, 0, 1'b0, 1'b0));
    cyc(1'b0, 1'b1, 1'b0, 1'b0, ex(1'b0, 0, 0, 0, 1'b0, 1'b0));
    flush();

    // Settle din low with the bench driving 0.
    phase = "settle";
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, ex(1'b0, 0, 0, 0, 1'b0, 1'b0));
    flush();

    // 3-cycle glitch is rejected.
    phase = "glitch";
    for (int i = 1; i <= 10; i++) cyc(1'b0, 1'b0, 1'b1, i <= 3, ex(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    flush();

    // 4-cycle high is accepted on edge 6; the fall back follows on edge 10.
    phase = "filt4";
    for (int i = 1; i <= 12; i++)
      cyc(1'b0, 1'b0, 1'b1, i <= 4, ex(1'b1, (i >= 6) && (i < 10), i == 6, i == 10, 1'b0, 1'b0));
    flush();

    // Reset asserted mid-OUT releases the pad before any clock edge.
    phase = "rst_mid";
    cyc(1'b1, 1'b1, 1'b0, 1'b0, ex(1'b0, 0, 0, 0, 1'b0, 1'b1));
    cyc(1'b1, 1'b1, 1'b0, 1'b0, ex(1'b0, 0, 0, 0, 1'b0, 1'b1));
    cyc(1'b1, 1'b1, 1'b0, 1'b0, ex(1'b0, 0, 0, 0, 1'b1, 1'b0));
    cyc(1'b1, 1'b1, 1'b0, 1'b0, ex(1'b0, 0, 0, 0, 1'b1, 1'b0));
    flush();
    chk("oe_pre", oe, 1'b1);
    #1 rst = 1'b1;
    #1;
    chk("oe_async", oe, 1'b0);
    chk("busy_async", busy, 1'b0);
    dir_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, ex(1'b0, 0, 0, 0, 1'b0, 1'b0));
    flush();

    // Readback contention: sticky flag, survives leaving OUT, cleared by err_clr.
    phase = "readback";
    cyc(1'b1, 1'b1, 1'b0, 1'b0, ex(1'b0, 0, 0, 0, 1'b0, 1'b1));
    cyc(1'b1, 1'b1, 1'b0, 1'b0, ex(1'b0, 0, 0, 0, 1'b0, 1'b1));
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, ex(1'b0, 0, 0, 0, 1'b1, 1'b0));
    flush();
`ifdef PAD_BIDIR_CTRL_READBACK_EN
    force pad = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("err_set", err, 1'b1);
    release pad;
    dir_req = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("err_sticky", err, 1'b1);
    chk("oe_in", oe, 1'b0);
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    chk("err_clr", err, 1'b0);
    @(posedge clk); #1;
    chk("err_hold", err, 1'b0);
`else
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    chk("err_off", err, 1'b0);
    dir_req = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("err_off_in", err, 1'b0);
    chk("oe_in", oe, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pad_bidir_ctrl.md
Name: pad_bidir_ctrl

Overview:
- Sequenced bidirectional GPIO pad controller: the driving/receiving end of the pad interface, as opposed to tie-off pads held permanently in input (hi-Z) mode.
- Switches a single PAD between receive and drive, with dead-cycle turnaround to avoid bus contention.
- Receives the pad through a 2-flop synchronizer, glitch filter and edge detector.
- Sits between SoC GPIO/peripheral logic and the physical pad ring on the FPGA target.

Parameters:
- TURN_CYCLES, 2, hi-Z dead cycles on each direction change; legal 1..15.
- FILT_CYCLES, 3, extra consecutive cycles a synchronized level must persist before DIN accepts it; legal 0..255; 0 = no filtering.
- RESET_LEVEL, 0, reset value of synchronizer flops and DIN.

Ports:
- CLK  input  1  single clock.
- RESET  input  1  asynchronous, active-high reset.
- DIR_REQ  input  1  1 = request drive mode, 0 = request receive mode.
- DOUT  input  1  value to drive on PAD in drive mode.
- PAD  inout  1  physical pad.
- DIN  output  1  filtered, synchronized pad level.
- DIN_RISE  output  1  one-cycle pulse when DIN goes 0->1.
- DIN_FALL  output  1  one-cycle pulse when DIN goes 1->0.
- OE  output  1  1 while PAD is actively driven.
- BUSY  output  1  1 during TURN_OUT or TURN_IN.
- ERR  output  1  sticky contention flag; optional feature only, otherwise 0.
- ERR_CLR  input  1  clears ERR.

Behaviour:
- Reset (asynchronous, immediate):
  - state=IN, OE=0, PAD hi-Z, BUSY=0, ERR=0, DIN_RISE=DIN_FALL=0.
  - Sync flops and DIN = RESET_LEVEL; all counters 0.
  - Reset asserted while driving releases PAD without waiting for a clock.
- Output path:
  - dout_q <= DOUT every edge.
  - PAD = dout_q when OE=1, else Z. DOUT-to-PAD latency is 1 cycle in OUT.
- FSM states IN, TURN_OUT, OUT, TURN_IN:
  - IN: OE=0, BUSY=0. DIR_REQ=1 -> TURN_OUT; load turn counter.
  - TURN_OUT: OE=0, BUSY=1; lasts exactly TURN_CYCLES cycles.
    - At expiry: DIR_REQ=1 -> OUT (OE=1 on that edge); DIR_REQ=0 -> IN.
    - DIR_REQ=0 before expiry -> IN on the next edge; OE never asserts.
  - OUT: OE=1, BUSY=0. DIR_REQ=0 -> TURN_IN; OE drops on that same edge.
  - TURN_IN: OE=0, BUSY=1; always runs the full TURN_CYCLES, then -> IN regardless of DIR_REQ. A DIR_REQ still high re-enters TURN_OUT the following cycle.
  - Net DIR_REQ rise (from IN) to OE=1: TURN_CYCLES+1 edges.
- Input path:
  - s1 <= PAD; s2 <= s1 every edge, including in drive mode, so the pad reads back.
  - Filter: DIN updates to s2 on the (FILT_CYCLES+1)th consecutive edge at which s2 != DIN. Any edge with s2 == DIN zeroes the count.
  - PAD change to DIN latency = 3+FILT_CYCLES edges.
  - Filter counter saturates; it never wraps.
- Edge pulses:
  - DIN_RISE/DIN_FALL are registered on the same edge DIN changes and are high for exactly one cycle.
  - Never both high.

Optional Feature:
- Macro: PAD_BIDIR_CTRL_READBACK_EN.
- Defined:
  - Track dout_q delayed 2 cycles to align with s2.
  - Once state has been OUT for >=3 consecutive cycles, any cycle with s2 != delayed dout_q sets ERR (sticky).
  - ERR_CLR=1 clears ERR on the next edge; a set in the same cycle wins over the clear.
  - Leaving OUT stops comparison but does not clear ERR.
- Undefined:
  - ERR tied to 0, ERR_CLR ignored, no compare logic or delay flops synthesized.

Test Plan:
- Reset with PAD pulled 1, RESET_LEVEL=0 -> DIN=0, OE=0, PAD Z. Release reset, PAD held 1 -> DIN=1 after 3+FILT_CYCLES edges (6 with defaults), DIN_RISE one pulse.
- Defaults; DIR_REQ 0->1 -> BUSY=1 for 2 cycles, OE=1 on 3rd edge. DOUT toggled 1,0,1 -> PAD follows 1 cycle later. DIR_REQ->0 -> OE=0 same edge, BUSY 2 cycles, back to IN.
- DIR_REQ pulse high 1 cycle only -> TURN_OUT aborts, OE never 1, state IN after 2 edges.
- FILT_CYCLES=3: PAD glitches 1 for 3 cycles -> DIN unchanged, no pulse. PAD 1 for 4+ cycles -> DIN=1, single DIN_RISE.
- Macro defined: in OUT driving 1, external force PAD=0 -> ERR=1 within 3 cycles and stays set after leaving OUT. ERR_CLR pulse -> ERR=0. Macro undefined: same stimulus -> ERR stays 0.
- RESET asserted mid-OUT -> PAD Z and OE=0 immediately (before next CLK edge); state IN after release.
